sa_cache_ctrl: RTL
==================

# sa_cache_ctrl

Parametrised N-way set-associative, write-back, write-allocate cache controller with true-LRU replacement. It sits between a single CPU-side requester and a slower memory port. Each line holds one DATA_W word. Compared with the previous controller, it adds a valid/ready CPU handshake, a memory req/ack port with dirty-victim write-back and read refill, and saturating hit/miss counters.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data word width
- SETS, 128, number of sets (power of 2); INDEX_W = log2(SETS)
- WAYS, 4, associativity (power of 2, ≥2); WAY_W = log2(WAYS)
- OFFSET_W, 9, low address bits ignored for lookup; TAG_W = ADDR_W − INDEX_W − OFFSET_W
- CNT_W, 16, statistics counter width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  request valid
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  request address; tag = [ADDR_W-1 -: TAG_W], index = [OFFSET_W +: INDEX_W]
- cpu_wdata  in  DATA_W  write data
- cpu_ready  out  1  high only in IDLE; request accepted when cpu_req && cpu_ready at a rising edge
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read result, valid with cpu_done, held until next read completes
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = write-back, 0 = refill read
- mem_addr  out  ADDR_W  line address; offset bits are zero
- mem_wdata  out  DATA_W  victim data
- mem_ack  in  1  completes transaction when sampled high with mem_req high
- mem_rdata  in  DATA_W  refill data, sampled on the ack edge
- hit_count, miss_count  out  CNT_W  saturating at all-ones
- current_state  out  3  encoded FSM state

## Operation
- States: IDLE=0, LOOKUP=1, WRITEBACK=2, REFILL=3, RESPOND=4.
- IDLE: on accept, register we/addr/wdata and go to LOOKUP. cpu_req outside IDLE is ignored.
- LOOKUP, hit (valid && tag match):
  - Increment hit_count.
  - Read: capture data into cpu_rdata. Write: update data and set dirty.
  - Apply the LRU touch. Go to RESPOND.
- LOOKUP, miss:
  - Increment miss_count.
  - Victim = lowest-index invalid way. If all ways are valid, victim = the way with age WAYS−1.
  - Victim valid and dirty → WRITEBACK.
  - Otherwise, read → REFILL; write → install (data=wdata, tag, valid=1, dirty=1, LRU touch) → RESPOND.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index, 0}, mem_wdata = victim data. On ack: victim dirty=0, valid=0, then:
  - read → REFILL;
  - write → install as above → RESPOND.
- REFILL: mem_req=1, mem_we=0, mem_addr={tag, index, 0}. On ack: install mem_rdata (valid=1, dirty=0), cpu_rdata=mem_rdata, LRU touch → RESPOND.
- RESPOND: cpu_done=1 for exactly one cycle, then → IDLE.
- LRU: ages per set form a permutation 0..WAYS−1, reset to age[w]=w. Touch of way k with old age a: age[k]=0; every way with age<a is incremented; all others are unchanged.
- Counters: saturate, never wrap.
- Data array is not reset; valid=0 makes its contents irrelevant.

## Timing
- Hit: accept at edge N, LOOKUP in cycle N+1, cpu_done high in cycle N+2, cpu_ready high again in cycle N+3.
- Clean read miss: cpu_done in the cycle after the ack edge.
- Clean write miss: same latency as a hit.
- mem_req, mem_we, mem_addr and mem_wdata are registered and stable from assertion until the ack edge. mem_req is low in the cycle after ack (WRITEBACK→REFILL re-asserts the following cycle).
- Ack is allowed on the first cycle of mem_req. mem_ack while mem_req is low is ignored.
- Reset values: cpu_done=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counters=0, state=IDLE (cpu_ready=1), all valid=0, dirty=0, ages=way index.
- Reset mid-transaction: mem_req drops asynchronously, the transaction is abandoned, and no cpu_done is issued.

## Test plan
- Reset, then read 0x0000_0000: refill with mem_addr 0x0000_0000; ack with 0x1234_5678 → cpu_rdata 0x1234_5678, miss_count=1. Reread → cpu_done 2 cycles after accept, no mem_req, hit_count=1.
- Write 0xAAAA_AAAA to 0x0000_0000 (hit), then read → 0xAAAA_AAAA, no memory traffic.
- Write tags 0–3 in set 0 (0x0000_0000…0x0003_0000, data D0–D3) with no mem_req. Then read 0x0004_0000 → write-back mem_addr 0x0000_0000 with D0, then refill 0x0004_0000.
- Fill as above, read 0x0000_0000 (hit), then write 0x0004_0000 → victim is tag 1: write-back to 0x0001_0000 with D1, no refill, cpu_done follows the ack.
- Hold mem_ack low for 5 cycles during a refill → mem_req and mem_addr stable, cpu_ready=0, pulsed cpu_req ignored, counters unchanged.
- Assert rst_n=0 during REFILL → mem_req=0 immediately, state IDLE. A subsequent read of a previously cached address misses.

Source files
------------

// File: rtl/sa_cache_ctrl.sv
// N-way set-associative write-back/write-allocate cache controller with true-LRU
// replacement, a valid/ready CPU port and a req/ack memory port.
module sa_cache_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SETS     = 128,
  parameter int WAYS     = 4,
  parameter int OFFSET_W = 9,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [2:0]        current_state
);

  localparam int INDEX_W = $clog2(SETS);
  localparam int WAY_W   = $clog2(WAYS);
  localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    REFILL    = 3'd3,
    RESPOND   = 3'd4
  } state_t;

  state_t state;

  logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
  logic [DATA_W-1:0] data_mem [SETS][WAYS];
  logic [WAYS-1:0]   valid    [SETS];
  logic [WAYS-1:0]   dirty    [SETS];
  logic [WAY_W-1:0]  age      [SETS][WAYS];

  logic               req_we;
  logic [TAG_W-1:0]   tag;
  logic [INDEX_W-1:0] idx;
  logic [DATA_W-1:0]  req_wdata;
  logic [WAY_W-1:0]   vic_r;

  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic [WAY_W-1:0]   oldest;
  logic [WAY_W-1:0]   victim;
  logic               vic_dirty;

  logic               arr_we;
  logic               touch_en;
  logic [WAY_W-1:0]   arr_way;
  logic [DATA_W-1:0]  arr_data;
  logic [WAY_W-1:0]   touch_age;

  logic               unused_offset;

  assign unused_offset = ^cpu_addr[OFFSET_W-1:0];
  assign cpu_ready     = (state == IDLE);
  assign current_state = state;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    oldest  = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid[idx][WAY_W'(w)] && tag_mem[idx][WAY_W'(w)] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (age[idx][WAY_W'(w)] == WAY_W'(WAYS - 1))
        oldest = WAY_W'(w);
    end
    // Scan from the top so the lowest-index invalid way ends up selected.
    victim = oldest;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!valid[idx][WAY_W'(WAYS - 1 - w)])
        victim = WAY_W'(WAYS - 1 - w);
    end
    vic_dirty = valid[idx][victim] && dirty[idx][victim];
  end

  // Every array install or hit applies exactly one LRU touch on arr_way.
  always_comb begin
    arr_we   = 1'b0;
    touch_en = 1'b0;
    arr_way  = hit_way;
    arr_data = req_wdata;
    case (state)
      LOOKUP: begin
        if (hit) begin
          touch_en = 1'b1;
          arr_we   = req_we;
        end else if (req_we && !vic_dirty) begin
          touch_en = 1'b1;
          arr_we   = 1'b1;
          arr_way  = victim;
        end
      end
      WRITEBACK: begin
        if (mem_req && mem_ack && req_we) begin
          touch_en = 1'b1;
          arr_we   = 1'b1;
          arr_way  = vic_r;
        end
      end
      REFILL: begin
        if (mem_req && mem_ack) begin
          touch_en = 1'b1;
          arr_we   = 1'b1;
          arr_way  = vic_r;
          arr_data = mem_rdata;
        end
      end
      default: ;
    endcase
    touch_age = age[idx][arr_way];
  end

  always_ff @(posedge clk) begin
    if (arr_we) begin
      data_mem[idx][arr_way] <= arr_data;
      tag_mem[idx][arr_way]  <= tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_we     <= 1'b0;
      tag        <= '0;
      idx        <= '0;
      req_wdata  <= '0;
      vic_r      <= '0;
      cpu_done   <= 1'b0;
      cpu_rdata  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid[INDEX_W'(s)] <= '0;
        dirty[INDEX_W'(s)] <= '0;
        for (int unsigned w = 0; w < WAYS; w++)
          age[INDEX_W'(s)][WAY_W'(w)] <= WAY_W'(w);
      end
    end else begin
      cpu_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            tag       <= cpu_addr[ADDR_W-1 -: TAG_W];
            idx       <= cpu_addr[OFFSET_W +: INDEX_W];
            req_wdata <= cpu_wdata;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (hit_count != '1) hit_count <= hit_count + 1'b1;
            if (!req_we) cpu_rdata <= data_mem[idx][hit_way];
            cpu_done <= 1'b1;
            state    <= RESPOND;
          end else begin
            if (miss_count != '1) miss_count <= miss_count + 1'b1;
            vic_r <= victim;
            if (vic_dirty) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= {tag_mem[idx][victim], idx, {OFFSET_W{1'b0}}};
              mem_wdata <= data_mem[idx][victim];
              state     <= WRITEBACK;
            end else if (!req_we) begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= {tag, idx, {OFFSET_W{1'b0}}};
              state    <= REFILL;
            end else begin
              cpu_done <= 1'b1;
              state    <= RESPOND;
            end
          end
        end
        WRITEBACK: begin
          if (mem_req && mem_ack) begin
            mem_req            <= 1'b0;
            mem_we             <= 1'b0;
            valid[idx][vic_r]  <= 1'b0;
            dirty[idx][vic_r]  <= 1'b0;
            cpu_done           <= req_we;
            state              <= req_we ? RESPOND : REFILL;
          end
        end
        REFILL: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {tag, idx, {OFFSET_W{1'b0}}};
          end else if (mem_ack) begin
            mem_req   <= 1'b0;
            cpu_rdata <= mem_rdata;
            cpu_done  <= 1'b1;
            state     <= RESPOND;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
      // Install updates come after the write-back invalidate so they take precedence.
      if (arr_we) begin
        valid[idx][arr_way] <= 1'b1;
        dirty[idx][arr_way] <= req_we;
      end
      if (touch_en) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == arr_way)
            age[idx][WAY_W'(w)] <= '0;
          else if (age[idx][WAY_W'(w)] < touch_age)
            age[idx][WAY_W'(w)] <= age[idx][WAY_W'(w)] + 1'b1;
        end
      end
    end
  end

endmodule
